seq_bitwise_logic_unit: RTL and testbench

Parametrised, multi-cycle bitwise logic unit for the ALU datapath. It generalises the fixed 32-bit XOR to any WIDTH and four selectable operations (AND/OR/XOR/NOR). It processes one SLICE-bit chunk per clock under a start/done handshake, so a single narrow slice of logic is reused across the word. The result is registered together with a zero flag for the ALU status logic.

---
 rtl/seq_bitwise_logic_unit.sv | 74 +++++++
 tb/tb_seq_bitwise_logic_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_bitwise_logic_unit.sv
// seq_bitwise_logic_unit: multi-cycle slice-serial AND/OR/XOR/NOR unit with start/done handshake and zero flag
module seq_bitwise_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = $clog2(NSLICE);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_part, r_out, w_result;
  logic             r_zero, w_last, w_load;
  logic [SLICE-1:0] w_as, w_bs, w_slice;
  // state register
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state: RUN walks all slices; IDLE and DONE both accept a new start
  always_comb begin
    w_last = r_cnt == CW'(NSLICE - 1);
    w_load = (r_state != RUN) && start;
    w_next = r_state == RUN ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  // apply the selected op to the current slice and merge it into the partial word
  always_comb begin
    w_as = r_a[r_cnt*SLICE +: SLICE];
    w_bs = r_b[r_cnt*SLICE +: SLICE];
    w_slice = r_op == 2'b00 ? (w_as & w_bs) :
              r_op == 2'b01 ? (w_as | w_bs) :
              r_op == 2'b10 ? (w_as ^ w_bs) : ~(w_as | w_bs);
    w_result = r_part;
    w_result[r_cnt*SLICE +: SLICE] = w_slice;
  end
  // operand capture, slice accumulation, and result publication on the last slice
  always_ff @(posedge clk)
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_part <= '0;
      r_cnt <= '0;
      r_out <= '0;
      r_zero <= 1'b0;
    end else if (w_load) begin
      r_a <= a;
      r_b <= b;
      r_op <= op;
      r_part <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_part <= w_result;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_out <= w_result;
        r_zero <= ~|w_result;
      end
    end
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  assign out  = r_out;
  assign zero = r_zero;
endmodule

// File: tb/tb_seq_bitwise_logic_unit.sv
// tb_seq_bitwise_logic_unit: directed checks of the slice-serial bitwise unit
module tb_seq_bitwise_logic_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero;
  logic [31:0] out;
  int          n_tests = 0, n_fail = 0;

  seq_bitwise_logic_unit #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 30) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input logic ez);
    int cyc, nb;
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    nb = busy ? 1 : 0;
    cyc = 0;
    while (!done && cyc < 30) begin
      step();
      cyc++;
      if (busy) nb++;
    end
    chk({tag, "_lat"}, cyc, 8);
    chk({tag, "_busy"}, nb, 8);
    chk({tag, "_out"}, out, exp);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
    step();
    chk({tag, "_pulse"}, {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    int viol, cyc, nd;
    step();
    step();
    reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (out !== 32'h0 || zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) viol++;
      step();
    end
    chk("idle_out", out, 32'h0);
    chk("idle_flags", {29'b0, zero, busy, done}, 32'd0);
    chk("idle_viol", viol, 0);

    run_op("xor", 2'b10, 32'hF0F01234, 32'h0FF0FFFF, 32'hFF00EDCB, 1'b0);
    run_op("and0", 2'b00, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1);
    run_op("nor", 2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    run_op("and", 2'b00, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0);

    op = 2'b01; a = 32'h80000001; b = 32'h00000002; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 32'hFFFFFFFF; b = 32'h12345678; op = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    chk("stab_busy", {31'b0, busy}, 32'd1);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        nd++;
        if (nd == 1) chk("stab_out", out, 32'h80000003);
      end
      step();
    end
    chk("stab_ndone", nd, 1);

    op = 2'b00; a = 32'h12345678; b = 32'h0F0F0F0F; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc);
    chk("b2b_first", out, 32'h02040608);
    op = 2'b10; a = 32'hAAAAAAAA; b = 32'h55555555; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_rerun", {30'b0, busy, done}, 32'd2);
    wait_done(cyc);
    chk("b2b_gap", cyc + 1, 9);
    chk("b2b_out", out, 32'hFFFFFFFF);
    step();

    op = 2'b11; a = 32'h0; b = 32'h0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_out", out, 32'h0);
    chk("rst_mid_flags", {29'b0, zero, busy, done}, 32'd0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) nd++;
      step();
    end
    chk("rst_mid_quiet", nd, 0);

    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    step();
    chk("rst_wins", {30'b0, busy, done}, 32'd0);

    run_op("post", 2'b01, 32'h00F000F0, 32'h0F000F00, 32'h0FF00FF0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
